// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader.
//   load_state_e   : loader FSM states
//   SYNC_BYTE      : frame start marker
//   DEFAULT_CLK_HZ : default system clock frequency in Hz
//   DEFAULT_BAUD   : default UART bit rate
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StCsum,
    StDone,
    StErr
  } load_state_e;

  localparam logic [7:0]  SYNC_BYTE      = 8'hA5;
  localparam int unsigned DEFAULT_CLK_HZ = 12000000;
  localparam int unsigned DEFAULT_BAUD   = 115200;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first.
//   clk, reset_n : system clock, async active-low reset
//   rx           : raw serial input (idles high), synchronized internally
//   byte_valid   : 1-cycle strobe, byte_data holds the received byte
//   byte_data    : last good byte
//   frame_err    : 1-cycle strobe when the stop bit sampled low
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e   state_q;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RxIdle;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state_q)
        RxIdle: begin
          cnt_q <= '0;
          // Only a true high-to-low edge starts a frame, so a line held low
          // after a bad stop bit cannot retrigger.
          if (rx_prev_q && !rx_sync_q) state_q <= RxStart;
        end
        RxStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RxData: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RxStop;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RxStop: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            state_q <= RxIdle;
            if (rx_sync_q) begin
              byte_valid <= 1'b1;
              byte_data  <= shift_q;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// Receives a checksummed program image over UART and writes it to
// instruction memory while holding the core in reset.
//   clk, reset_n : system clock, async active-low reset
//   uart_rx      : serial input, 8N1
//   core_hold    : high keeps the core in reset
//   mem_we       : 1-cycle write strobe; mem_addr / mem_wdata qualify it
//   load_done    : last frame accepted, core released
//   load_err     : last frame rejected
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
  parameter int unsigned BAUD   = DEFAULT_BAUD,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              uart_rx,
  output logic              core_hold,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [16:0] MaxWords     = 17'(2 ** ADDR_W);

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  load_state_e state_q;
  logic [7:0]  sum_q;
  logic [15:0] len_q;
  logic [15:0] word_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] word_q;
  logic [15:0] len_full;
  logic [31:0] word_next;

  assign len_full  = {byte_data, len_q[7:0]};
  assign word_next = {byte_data, word_q[31:8]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sum_q      <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      core_hold  <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (frame_err) begin
        if (state_q inside {StLen0, StLen1, StData, StCsum}) begin
          state_q   <= StErr;
          core_hold <= 1'b1;
          load_err  <= 1'b1;
        end
      end else if (byte_valid) begin
        unique case (state_q)
          StIdle, StDone, StErr: begin
            if (byte_data == SYNC_BYTE) begin
              state_q    <= StLen0;
              sum_q      <= '0;
              word_cnt_q <= '0;
              byte_cnt_q <= '0;
              core_hold  <= 1'b1;
              load_done  <= 1'b0;
              load_err   <= 1'b0;
            end
          end
          StLen0: begin
            len_q[7:0] <= byte_data;
            sum_q      <= sum_q + byte_data;
            state_q    <= StLen1;
          end
          StLen1: begin
            len_q <= len_full;
            sum_q <= sum_q + byte_data;
            if ({1'b0, len_full} > MaxWords) begin
              state_q  <= StErr;
              load_err <= 1'b1;
            end else if (len_full == 16'd0) begin
              state_q <= StCsum;
            end else begin
              state_q <= StData;
            end
          end
          StData: begin
            word_q     <= word_next;
            sum_q      <= sum_q + byte_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              mem_we     <= 1'b1;
              mem_addr   <= word_cnt_q[ADDR_W-1:0];
              mem_wdata  <= word_next;
              word_cnt_q <= word_cnt_q + 16'd1;
              if (word_cnt_q == len_q - 16'd1) state_q <= StCsum;
            end
          end
          StCsum: begin
            if (byte_data == sum_q) begin
              state_q   <= StDone;
              core_hold <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state_q  <= StErr;
              load_err <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed/randomized bench for program_loader with a frame-level model.
module tb_program_loader;

  localparam int BIT    = 104;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              rx_line = 1'b1;
  logic              core_hold, mem_we, load_done, load_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  program_loader #(
    .CLK_HZ(12000000),
    .BAUD  (115200),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .uart_rx  (rx_line),
    .core_hold(core_hold),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .load_done(load_done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_words[$];
  logic [7:0]  frame_q[$];
  bit          exp_done, exp_err;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_addr.push_back(32'(mem_addr));
      got_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    rx_line = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_line = stop_ok;
    repeat (BIT) @(negedge clk);
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
    repeat (20) @(negedge clk);
  endtask

  // Frame-level model: find sync, read length, collect words, verify checksum.
  task automatic model_run();
    int i = 0;
    int n, sum, w;
    exp_words.delete();
    exp_done = 0;
    exp_err  = 0;
    while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
    if (i >= frame_q.size()) return;
    n   = int'(frame_q[i+1]) + 256 * int'(frame_q[i+2]);
    sum = int'(frame_q[i+1]) + int'(frame_q[i+2]);
    if (n > (1 << ADDR_W)) begin
      exp_err = 1;
      return;
    end
    i += 3;
    for (int k = 0; k < n; k++) begin
      w = 0;
      for (int j = 0; j < 4; j++) begin
        w   += int'(frame_q[i+j]) << (8 * j);
        sum += int'(frame_q[i+j]);
      end
      exp_words.push_back(32'(w));
      i += 4;
    end
    if ((sum % 256) == int'(frame_q[i])) exp_done = 1;
    else exp_err = 1;
  endtask

  task automatic build_frame(input int n, input bit good);
    int sum = n % 256 + n / 256;
    logic [31:0] w;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      for (int j = 0; j < 4; j++) begin
        frame_q.push_back(w[8*j +: 8]);
        sum += int'(w[8*j +: 8]);
      end
    end
    frame_q.push_back(good ? 8'(sum) : 8'(sum + 1));
  endtask

  task automatic check_result(input string tag);
    check({tag, ".nwrites"}, 32'(got_data.size()), 32'(exp_words.size()));
    foreach (exp_words[i]) begin
      check({tag, ".addr"}, (i < got_addr.size()) ? got_addr[i] : 'x, 32'(i));
      check({tag, ".data"}, (i < got_data.size()) ? got_data[i] : 'x, exp_words[i]);
    end
    check({tag, ".load_done"}, 32'(load_done), 32'(exp_done));
    check({tag, ".load_err"}, 32'(load_err), 32'(exp_err));
    check({tag, ".core_hold"}, 32'(core_hold), 32'(!exp_done));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".core_hold"}, 32'(core_hold), 32'd1);
    check({tag, ".mem_we"}, 32'(mem_we), 32'd0);
    check({tag, ".mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    check({tag, ".load_done"}, 32'(load_done), 32'd0);
    check({tag, ".load_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Reference two-word frame
    frame_q = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h6F, 8'h00, 8'h00, 8'h00, 8'h84};
    got_addr.delete(); got_data.delete();
    model_run();
    check("ref.model_done", 32'(exp_done), 32'd1);
    send_frame();
    check_result("ref");
    check("ref.word0", (got_data.size() > 0) ? got_data[0] : 'x, 32'h0000_0013);
    check("ref.word1", (got_data.size() > 1) ? got_data[1] : 'x, 32'h0000_006F);

    // Same frame, bad checksum
    frame_q[11] = 8'h85;
    got_addr.delete(); got_data.delete();
    model_run();
    send_frame();
    check_result("badcsum");

    // Junk before sync, zero-length frame
    frame_q = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    got_addr.delete(); got_data.delete();
    model_run();
    send_frame();
    check_result("zerolen");

    // Length above memory size
    frame_q = {8'hA5, 8'h01, 8'h04};
    got_addr.delete(); got_data.delete();
    model_run();
    send_frame();
    check_result("toolong");

    // Framing error on 2nd payload byte, then a good random frame
    got_addr.delete(); got_data.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    repeat (20) @(negedge clk);
    check("ferr.load_err", 32'(load_err), 32'd1);
    check("ferr.core_hold", 32'(core_hold), 32'd1);
    check("ferr.nwrites", 32'(got_data.size()), 32'd0);
    build_frame(1, 1'b1);
    got_addr.delete(); got_data.delete();
    model_run();
    send_frame();
    check_result("after_ferr");

    // Reset in the middle of a load after 5 payload bytes
    build_frame(2, 1'b1);
    got_addr.delete(); got_data.delete();
    for (int i = 0; i < 8; i++) send_byte(frame_q[i], 1'b1);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    check("midreset.writes_before", 32'(got_data.size()), 32'd1);
    got_addr.delete(); got_data.delete();
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    check("midreset.no_we", 32'(got_data.size()), 32'd0);
    build_frame(2, 1'b1);
    model_run();
    send_frame();
    check_result("fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
